alu_seq: RTL and testbench

- Multi-cycle sequencer that owns the 16-bit ALU's operand and control inputs.
- It performs 16x16 multiply (low 16 bits) and variable left shift as a series of single-cycle ALU add operations.
- When idle, it passes the CPU's ALU controls straight through, so microcode sees the ALU unchanged.
- It sits between the control unit and the ALU and uses only the ALU's val and C_flag outputs.

---
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle MUL / SHL sequencer that borrows the external 16-bit ALU for its adds.
// When idle the CPU's ALU controls pass straight through to the ALU.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    input  logic [WIDTH-1:0] cpu_x,
    input  logic [WIDTH-1:0] cpu_y,
    input  logic [5:0]       cpu_c,
    input  logic             cpu_cin,
    input  logic             cpu_en,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_c,
    output logic             alu_cin,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_val,
    input  logic             alu_cflag
);

    localparam logic [5:0] CAdd = 6'b101010;

    typedef enum logic [1:0] {StIdle, StStep, StDbl, StFin} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             op_q, op_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             q_more;

    // A doubling carry only matters if more multiplier bits remain to use it.
    assign q_more = |q_q[WIDTH-1:1];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        m_d      = m_q;
        q_d      = q_q;
        result_d = result_q;
        op_d     = op_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StStep;
                    if (!op) begin
                        acc_d = '0;
                        m_d   = a;
                        q_d   = b;
                    end else begin
                        acc_d = a;
                        q_d   = WIDTH'(b[CNTW-1:0]);
                    end
                end
            end
            StStep: begin
                if (q_q == '0) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = StFin;
                end else if (op_q) begin
                    acc_d = alu_val;
                    ovf_d = ovf_q | alu_cflag;
                    q_d   = q_q - WIDTH'(1);
                end else if (q_q[0]) begin
                    acc_d   = alu_val;
                    ovf_d   = ovf_q | alu_cflag;
                    state_d = StDbl;
                end else begin
                    m_d = alu_val;
                    if (q_more) ovf_d = ovf_q | alu_cflag;
                    q_d = q_q >> 1;
                end
            end
            StDbl: begin
                m_d = alu_val;
                if (q_more) ovf_d = ovf_q | alu_cflag;
                q_d     = q_q >> 1;
                state_d = StStep;
            end
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (state_q == StIdle) begin
            alu_x   = cpu_x;
            alu_y   = cpu_y;
            alu_c   = cpu_c;
            alu_cin = cpu_cin;
            alu_en  = cpu_en;
        end else begin
            alu_c   = CAdd;
            alu_cin = 1'b0;
            alu_en  = 1'b0;
            alu_x   = m_q;
            alu_y   = m_q;
            if (state_q == StStep && op_q) begin
                alu_x = acc_q;
                alu_y = acc_q;
            end else if (state_q == StStep && q_q[0]) begin
                alu_x = acc_q;
                alu_y = m_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            m_q      <= '0;
            q_q      <= '0;
            result_q <= '0;
            op_q     <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            q_q      <= q_d;
            result_q <= result_d;
            op_q     <= op_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq with a behavioural ALU and reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, ovf;
    logic [15:0] result;
    logic [15:0] cpu_x = '0, cpu_y = '0;
    logic [5:0]  cpu_c = '0;
    logic        cpu_cin = 1'b0, cpu_en = 1'b0;
    logic [15:0] alu_x, alu_y, alu_val;
    logic [5:0]  alu_c;
    logic        alu_cin, alu_en, alu_cflag;

    alu_seq #(.WIDTH(16), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .ovf(ovf),
        .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_c(cpu_c), .cpu_cin(cpu_cin), .cpu_en(cpu_en),
        .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_cin(alu_cin), .alu_en(alu_en),
        .alu_val(alu_val), .alu_cflag(alu_cflag)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: only X+Y is needed by the sequencer.
    always_comb begin
        {alu_cflag, alu_val} = {1'b0, alu_x} + {1'b0, alu_y};
        if (alu_c != 6'b101010) begin
            alu_val   = alu_x & alu_y;
            alu_cflag = 1'b0;
        end
    end

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          lat;
        int          st;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Reference: true product / shift in 32 bits; lost high bits mean overflow.
    function automatic exp_t model(input logic o, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [31:0] p;
        int          nbits;
        if (!o) begin
            p     = 32'(x) * 32'(y);
            nbits = 0;
            for (int i = 0; i < 16; i++) if (y[i]) nbits = i + 1;
            e.lat = 2 + nbits + $countones(y);
        end else begin
            p     = 32'(x) << y[3:0];
            e.lat = int'(y[3:0]) + 2;
        end
        e.res = p[15:0];
        e.ovf = (p[31:16] != 16'h0);
        e.st  = 0;
        return e;
    endfunction

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 want none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("latency", 32'(cyc - e.st), 32'(e.lat));
            end
            n_done++;
        end
    end

    task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e     = model(o, x, y);
        e.st  = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        a       = 16'($urandom);
        b       = 16'($urandom);
        cpu_x   = 16'($urandom);
        cpu_en  = 1'b1;
        cpu_cin = 1'b1;
        cpu_c   = 6'($urandom);
        chk("busy_in_op", 32'(busy), 32'(1));
        chk("alu_en_in_op", 32'(alu_en), 32'(0));
        chk("alu_c_in_op", 32'(alu_c), 32'(6'b101010));
        chk("alu_cin_in_op", 32'(alu_cin), 32'(0));
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (n_done < target) begin
            n_chk++;
            n_bad++;
            $display("FAIL timeout: got done_count=%0d want %0d", n_done, target);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y);
        int target;
        target = n_done + 1;
        issue(o, x, y);
        wait_done(target);
    endtask

    initial begin
        cpu_x   = 16'h1234;
        cpu_y   = 16'h00A5;
        cpu_c   = 6'b101010;
        cpu_cin = 1'b1;
        cpu_en  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("pt_alu_x", 32'(alu_x), 32'h1234);
        chk("pt_alu_y", 32'(alu_y), 32'h00A5);
        chk("pt_alu_c", 32'(alu_c), 32'(6'b101010));
        chk("pt_alu_cin", 32'(alu_cin), 32'(1));
        chk("pt_alu_en", 32'(alu_en), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));

        run_op(1'b0, 16'h0003, 16'h0005);
        run_op(1'b0, 16'hFFFF, 16'h0002);
        run_op(1'b0, 16'h1234, 16'h0000);
        run_op(1'b1, 16'h0001, 16'h000F);
        run_op(1'b1, 16'h8001, 16'h0001);
        run_op(1'b1, 16'hBEEF, 16'hFFF0);

        // Second start mid-MUL must be ignored.
        begin
            int target;
            target = n_done + 1;
            issue(1'b0, 16'h0102, 16'h0033);
            @(negedge clk);
            start = 1'b1;
            op    = 1'b1;
            a     = 16'hFFFF;
            b     = 16'h0007;
            @(negedge clk);
            start = 1'b0;
            wait_done(target);
            repeat (3) @(negedge clk);
            chk("no_extra_done", 32'(n_done), 32'(target));
        end

        for (int i = 0; i < 40; i++) begin
            logic        o;
            logic [15:0] x, y;
            o = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            y = 16'($urandom) >> $urandom_range(0, 15);
            run_op(o, x, y);
        end
        run_op(1'b0, 16'h00FF, 16'h0101);

        // Reset mid-MUL aborts with no done pulse.
        issue(1'b0, 16'hFFFF, 16'hFFFF);
        repeat (5) @(negedge clk);
        cpu_x  = 16'h5A5A;
        cpu_en = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_alu_x", 32'(alu_x), 32'h5A5A);
        chk("abort_alu_en", 32'(alu_en), 32'(1));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        chk("pending", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
